// File: rtl/dma_ch_arbiter.sv
// Channel arbiter: collects channel descriptors while idle, then serves them one at a time,
// highest priority first, to the transfer engine over a valid/ready grant handshake.
module dma_ch_arbiter #(
   parameter int NUM_SLOTS = 8
) (
   input  logic        AXI_aclk,
   input  logic        AXI_areset,
   input  logic        arbSample,
   input  logic [5:0]  arbCurrentChannelSample,
   input  logic [3:0]  arbChannelPriority,
   input  logic [31:0] arbChannelTransferSize,
   input  logic        arbitrate,
   output logic        arbWriteTransactionsDone,
   output logic [5:0]  ch_id,
   output logic        ch_done,
   output logic        xfer_valid,
   input  logic        xfer_ready,
   output logic [5:0]  xfer_ch_id,
   output logic [31:0] xfer_size,
   input  logic        xfer_done,
   output logic        busy,
   output logic        sample_overflow
);

   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic              slot_valid_q [NUM_SLOTS];
   logic              slot_valid_d [NUM_SLOTS];
   logic [5:0]        slot_id_q    [NUM_SLOTS];
   logic [5:0]        slot_id_d    [NUM_SLOTS];
   logic [3:0]        slot_prio_q  [NUM_SLOTS];
   logic [3:0]        slot_prio_d  [NUM_SLOTS];
   logic [31:0]       slot_size_q  [NUM_SLOTS];
   logic [31:0]       slot_size_d  [NUM_SLOTS];

   logic [IDX_W-1:0]  win_slot_q, win_slot_d;
   logic [5:0]        win_id_q, win_id_d;
   logic [5:0]        xfer_ch_id_q, xfer_ch_id_d;
   logic [31:0]       xfer_size_q, xfer_size_d;
   logic              xfer_valid_q, xfer_valid_d;
   logic              ch_done_q, ch_done_d;
   logic [5:0]        ch_id_q, ch_id_d;
   logic              wr_done_q, wr_done_d;
   logic              busy_q, busy_d;
   logic              overflow_q, overflow_d;

   logic              sel_found_s;
   logic [3:0]        sel_prio_s;
   logic [IDX_W-1:0]  sel_idx_s;
   logic [5:0]        sel_id_s;
   logic [31:0]       sel_size_s;

   logic              hit_found_s;
   logic [IDX_W-1:0]  hit_idx_s;
   logic              free_found_s;
   logic [IDX_W-1:0]  free_idx_s;

   // Winner search: strict greater-than while scanning upward keeps ties on the lowest slot.
   always_comb begin
      sel_found_s = 1'b0;
      sel_prio_s  = 4'd0;
      sel_idx_s   = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (slot_valid_q[i] && (!sel_found_s || (slot_prio_q[i] > sel_prio_s))) begin
            sel_found_s = 1'b1;
            sel_prio_s  = slot_prio_q[i];
            sel_idx_s   = IDX_W'(i);
         end else begin
            sel_found_s = sel_found_s;
         end
      end
      sel_id_s   = slot_id_q[sel_idx_s];
      sel_size_s = slot_size_q[sel_idx_s];
   end

   // Sample placement: first valid slot holding the same id, and first free slot.
   always_comb begin
      hit_found_s  = 1'b0;
      hit_idx_s    = {IDX_W{1'b0}};
      free_found_s = 1'b0;
      free_idx_s   = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!hit_found_s && slot_valid_q[i] && (slot_id_q[i] == arbCurrentChannelSample)) begin
            hit_found_s = 1'b1;
            hit_idx_s   = IDX_W'(i);
         end else begin
            hit_found_s = hit_found_s;
         end
         if (!free_found_s && !slot_valid_q[i]) begin
            free_found_s = 1'b1;
            free_idx_s   = IDX_W'(i);
         end else begin
            free_found_s = free_found_s;
         end
      end
   end

   // Next-state, table update and registered-output computation.
   always_comb begin
      state_d      = state_q;
      slot_valid_d = slot_valid_q;
      slot_id_d    = slot_id_q;
      slot_prio_d  = slot_prio_q;
      slot_size_d  = slot_size_q;
      win_slot_d   = win_slot_q;
      win_id_d     = win_id_q;
      xfer_ch_id_d = xfer_ch_id_q;
      xfer_size_d  = xfer_size_q;
      ch_id_d      = ch_id_q;
      overflow_d   = overflow_q;

      case (state_q)
         ST_IDLE: begin
            if (arbSample) begin
               if (hit_found_s) begin
                  slot_prio_d[hit_idx_s] = arbChannelPriority;
                  slot_size_d[hit_idx_s] = arbChannelTransferSize;
               end else if (free_found_s) begin
                  slot_valid_d[free_idx_s] = 1'b1;
                  slot_id_d[free_idx_s]    = arbCurrentChannelSample;
                  slot_prio_d[free_idx_s]  = arbChannelPriority;
                  slot_size_d[free_idx_s]  = arbChannelTransferSize;
               end else begin
                  overflow_d = 1'b1;
               end
            end else begin
               overflow_d = overflow_q;
            end
            // Starting a batch clears the overflow flag, even over a same-cycle drop.
            if (arbitrate) begin
               state_d    = ST_SELECT;
               overflow_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SELECT: begin
            if (!sel_found_s) begin
               state_d = ST_FINISH;
            end else begin
               win_slot_d = sel_idx_s;
               win_id_d   = sel_id_s;
               if (sel_size_s == 32'd0) begin
                  state_d = ST_DONE;
               end else begin
                  xfer_ch_id_d = sel_id_s;
                  xfer_size_d  = sel_size_s;
                  state_d      = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (xfer_ready) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (xfer_done) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            slot_valid_d[win_slot_q] = 1'b0;
            state_d                  = ST_SELECT;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so the flops line up with the state register.
      xfer_valid_d = (state_d == ST_ISSUE);
      ch_done_d    = (state_d == ST_DONE);
      wr_done_d    = (state_d == ST_FINISH);
      busy_d       = (state_d != ST_IDLE);
      if (state_d == ST_DONE) begin
         ch_id_d = win_id_d;
      end else begin
         ch_id_d = ch_id_q;
      end
   end

   // State, descriptor table and output registers with synchronous reset.
   always_ff @(posedge AXI_aclk) begin
      if (AXI_areset) begin
         state_q      <= ST_IDLE;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_valid_q[i] <= 1'b0;
            slot_id_q[i]    <= 6'd0;
            slot_prio_q[i]  <= 4'd0;
            slot_size_q[i]  <= 32'd0;
         end
         win_slot_q   <= {IDX_W{1'b0}};
         win_id_q     <= 6'd0;
         xfer_ch_id_q <= 6'd0;
         xfer_size_q  <= 32'd0;
         xfer_valid_q <= 1'b0;
         ch_done_q    <= 1'b0;
         ch_id_q      <= 6'd0;
         wr_done_q    <= 1'b0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_valid_q <= slot_valid_d;
         slot_id_q    <= slot_id_d;
         slot_prio_q  <= slot_prio_d;
         slot_size_q  <= slot_size_d;
         win_slot_q   <= win_slot_d;
         win_id_q     <= win_id_d;
         xfer_ch_id_q <= xfer_ch_id_d;
         xfer_size_q  <= xfer_size_d;
         xfer_valid_q <= xfer_valid_d;
         ch_done_q    <= ch_done_d;
         ch_id_q      <= ch_id_d;
         wr_done_q    <= wr_done_d;
         busy_q       <= busy_d;
         overflow_q   <= overflow_d;
      end
   end

   assign arbWriteTransactionsDone = wr_done_q;
   assign ch_id                    = ch_id_q;
   assign ch_done                  = ch_done_q;
   assign xfer_valid               = xfer_valid_q;
   assign xfer_ch_id               = xfer_ch_id_q;
   assign xfer_size                = xfer_size_q;
   assign busy                     = busy_q;
   assign sample_overflow          = sample_overflow_w();

   function automatic logic sample_overflow_w();
      return overflow_q;
   endfunction

endmodule

// File: tb/tb_dma_ch_arbiter.sv
// Self-checking bench for dma_ch_arbiter: directed scenarios plus randomized batches
// checked cycle-exactly against a descriptor-table model and a priority-ordered service list.
module tb_dma_ch_arbiter;

   localparam int NS = 8;

   logic        clk = 1'b0;
   logic        AXI_areset;
   logic        arbSample;
   logic [5:0]  arbCurrentChannelSample;
   logic [3:0]  arbChannelPriority;
   logic [31:0] arbChannelTransferSize;
   logic        arbitrate;
   logic        arbWriteTransactionsDone;
   logic [5:0]  ch_id;
   logic        ch_done;
   logic        xfer_valid;
   logic        xfer_ready;
   logic [5:0]  xfer_ch_id;
   logic [31:0] xfer_size;
   logic        xfer_done;
   logic        busy;
   logic        sample_overflow;

   always #5 clk = ~clk;

   dma_ch_arbiter #(.NUM_SLOTS(NS)) dut (
      .AXI_aclk                 (clk),
      .AXI_areset               (AXI_areset),
      .arbSample                (arbSample),
      .arbCurrentChannelSample  (arbCurrentChannelSample),
      .arbChannelPriority       (arbChannelPriority),
      .arbChannelTransferSize   (arbChannelTransferSize),
      .arbitrate                (arbitrate),
      .arbWriteTransactionsDone (arbWriteTransactionsDone),
      .ch_id                    (ch_id),
      .ch_done                  (ch_done),
      .xfer_valid               (xfer_valid),
      .xfer_ready               (xfer_ready),
      .xfer_ch_id               (xfer_ch_id),
      .xfer_size                (xfer_size),
      .xfer_done                (xfer_done),
      .busy                     (busy),
      .sample_overflow          (sample_overflow)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Descriptor table as the channel-configuration side sees it.
   bit          m_valid [NS];
   int          m_id    [NS];
   int          m_prio  [NS];
   logic [31:0] m_size  [NS];
   bit          m_ovf;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_sample(input int id, input int prio, input logic [31:0] size);
      int hit  = -1;
      int free = -1;
      for (int s = 0; s < NS; s++) begin
         if (m_valid[s] && m_id[s] == id && hit < 0) hit = s;
         if (!m_valid[s] && free < 0) free = s;
      end
      if (hit >= 0) begin
         m_prio[hit] = prio;
         m_size[hit] = size;
      end else if (free >= 0) begin
         m_valid[free] = 1'b1;
         m_id[free]    = id;
         m_prio[free]  = prio;
         m_size[free]  = size;
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic do_sample(input int id, input int prio, input logic [31:0] size);
      int id_v   = id;
      int prio_v = prio;
      arbSample               = 1'b1;
      arbCurrentChannelSample = id_v[5:0];
      arbChannelPriority      = prio_v[3:0];
      arbChannelTransferSize  = size;
      model_sample(id, prio, size);
      @(negedge clk);
      arbSample = 1'b0;
      check_eq("sample_overflow", {63'd0, sample_overflow}, {63'd0, m_ovf});
   endtask

   // Runs one batch; we stay aligned to negedges so each check sees one whole cycle.
   task automatic run_batch(input int rdy_dly, input int done_dly, input bit disturb);
      int          eid [$];
      logic [31:0] esz [$];
      // Service order: higher priority first, lower slot first on ties (key packs both).
      forever begin
         int best = -1;
         int best_key = -1;
         for (int s = 0; s < NS; s++) begin
            if (m_valid[s] && (m_prio[s] * 64 + (63 - s)) > best_key) begin
               best_key = m_prio[s] * 64 + (63 - s);
               best     = s;
            end
         end
         if (best < 0) break;
         eid.push_back(m_id[best]);
         esz.push_back(m_size[best]);
         m_valid[best] = 1'b0;
      end

      arbitrate = 1'b1;
      @(negedge clk);
      arbitrate = 1'b0;
      m_ovf     = 1'b0;
      check_eq("select_busy", {63'd0, busy}, 64'd1);
      check_eq("ovf_cleared", {63'd0, sample_overflow}, 64'd0);
      check_eq("select_no_valid", {63'd0, xfer_valid}, 64'd0);

      for (int k = 0; k < eid.size(); k++) begin
         @(negedge clk);
         if (esz[k] == 32'd0) begin
            check_eq("zero_ch_done", {63'd0, ch_done}, 64'd1);
            check_eq("zero_ch_id", {58'd0, ch_id}, 64'(eid[k]));
            check_eq("zero_no_grant", {63'd0, xfer_valid}, 64'd0);
         end else begin
            check_eq("grant_valid", {63'd0, xfer_valid}, 64'd1);
            check_eq("grant_id", {58'd0, xfer_ch_id}, 64'(eid[k]));
            check_eq("grant_size", {32'd0, xfer_size}, {32'd0, esz[k]});
            for (int d = 0; d < rdy_dly; d++) begin
               if (d == 0 && disturb) begin
                  xfer_done               = 1'b1;
                  arbitrate               = 1'b1;
                  arbSample               = 1'b1;
                  arbCurrentChannelSample = 6'($urandom_range(0, 63));
                  arbChannelPriority      = 4'd15;
                  arbChannelTransferSize  = 32'd4;
               end
               @(negedge clk);
               xfer_done = 1'b0;
               arbitrate = 1'b0;
               arbSample = 1'b0;
               check_eq("hold_valid", {63'd0, xfer_valid}, 64'd1);
               check_eq("hold_id", {58'd0, xfer_ch_id}, 64'(eid[k]));
               check_eq("hold_size", {32'd0, xfer_size}, {32'd0, esz[k]});
               check_eq("issue_no_done", {63'd0, ch_done}, 64'd0);
            end
            xfer_ready = 1'b1;
            @(negedge clk);
            xfer_ready = 1'b0;
            check_eq("wait_valid_low", {63'd0, xfer_valid}, 64'd0);
            for (int d = 1; d < done_dly; d++) begin
               @(negedge clk);
               check_eq("wait_no_done", {63'd0, ch_done}, 64'd0);
            end
            xfer_done = 1'b1;
            @(negedge clk);
            xfer_done = 1'b0;
            check_eq("ch_done", {63'd0, ch_done}, 64'd1);
            check_eq("ch_id", {58'd0, ch_id}, 64'(eid[k]));
            check_eq("done_hold_id", {58'd0, xfer_ch_id}, 64'(eid[k]));
         end
         @(negedge clk);
         check_eq("reselect_pulse_end", {63'd0, ch_done}, 64'd0);
         check_eq("reselect_busy", {63'd0, busy}, 64'd1);
      end

      @(negedge clk);
      check_eq("batch_done", {63'd0, arbWriteTransactionsDone}, 64'd1);
      check_eq("finish_no_grant", {63'd0, xfer_valid}, 64'd0);
      @(negedge clk);
      check_eq("batch_done_pulse", {63'd0, arbWriteTransactionsDone}, 64'd0);
      check_eq("idle_busy", {63'd0, busy}, 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_valid"}, {63'd0, xfer_valid}, 64'd0);
      check_eq({tag, "_xid"}, {58'd0, xfer_ch_id}, 64'd0);
      check_eq({tag, "_xsize"}, {32'd0, xfer_size}, 64'd0);
      check_eq({tag, "_chdone"}, {63'd0, ch_done}, 64'd0);
      check_eq({tag, "_chid"}, {58'd0, ch_id}, 64'd0);
      check_eq({tag, "_wrdone"}, {63'd0, arbWriteTransactionsDone}, 64'd0);
      check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check_eq({tag, "_ovf"}, {63'd0, sample_overflow}, 64'd0);
   endtask

   initial begin
      AXI_areset              = 1'b1;
      arbSample               = 1'b0;
      arbCurrentChannelSample = 6'd0;
      arbChannelPriority      = 4'd0;
      arbChannelTransferSize  = 32'd0;
      arbitrate               = 1'b0;
      xfer_ready              = 1'b0;
      xfer_done               = 1'b0;
      for (int s = 0; s < NS; s++) m_valid[s] = 1'b0;
      m_ovf = 1'b0;
      @(negedge clk);
      @(negedge clk);
      AXI_areset = 1'b0;
      check_all_zero("reset");

      // Basic priority order with tie on 5 and 9.
      do_sample(3, 2, 32'd64);
      do_sample(5, 7, 32'd128);
      do_sample(9, 7, 32'd32);
      run_batch(0, 4, 1'b0);

      // Empty batch.
      run_batch(0, 1, 1'b0);

      // Overflow, then in-place overwrite promoting id 3.
      do_sample(3, 1, 32'd8);
      for (int i = 0; i < NS - 1; i++) do_sample(10 + i, 2 + (i % 5), 32'(16 * (i + 1)));
      do_sample(40, 15, 32'd999);
      check_eq("overflow_set", {63'd0, sample_overflow}, 64'd1);
      do_sample(3, 15, 32'd72);
      run_batch(1, 2, 1'b0);

      // Stalled grant with xfer_done, arbitrate and a sample all thrown at ISSUE.
      do_sample(30, 5, 32'd256);
      do_sample(31, 4, 32'd512);
      run_batch(10, 3, 1'b1);

      // Zero-size channel ahead of channel 7.
      do_sample(20, 9, 32'd0);
      do_sample(7, 1, 32'd16);
      run_batch(0, 1, 1'b0);

      // Reset during WAIT abandons the grant.
      do_sample(12, 4, 32'd100);
      arbitrate = 1'b1;
      @(negedge clk);
      arbitrate = 1'b0;
      @(negedge clk);
      check_eq("rst_pre_grant", {63'd0, xfer_valid}, 64'd1);
      xfer_ready = 1'b1;
      @(negedge clk);
      xfer_ready = 1'b0;
      AXI_areset = 1'b1;
      @(negedge clk);
      AXI_areset = 1'b0;
      for (int s = 0; s < NS; s++) m_valid[s] = 1'b0;
      m_ovf = 1'b0;
      check_all_zero("midrst");
      xfer_done = 1'b1;
      @(negedge clk);
      xfer_done = 1'b0;
      check_eq("late_done_ignored", {63'd0, ch_done}, 64'd0);
      @(negedge clk);
      check_eq("late_done_ignored2", {63'd0, ch_done}, 64'd0);
      do_sample(21, 3, 32'd48);
      run_batch(0, 2, 1'b0);

      // Randomized batches with duplicate ids, zero sizes and occasional overflow.
      for (int b = 0; b < 25; b++) begin
         int nsamp = $urandom_range(0, 11);
         for (int i = 0; i < nsamp; i++) begin
            logic [31:0] sz;
            sz = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            do_sample($urandom_range(0, 15), $urandom_range(0, 15), sz);
         end
         run_batch($urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dma_ch_arbiter.md
# dma_ch_arbiter

Channel arbiter between the channel-configuration FSM and the AXI transfer engine. It collects per-channel descriptors (id, priority, transfer size) strobed out by the configuration FSM. On `arbitrate` it serves the collected channels one at a time, highest priority first, handing each to the transfer engine over a valid/ready handshake. It reports each completion back (`ch_id`/`ch_done`) and signals `arbWriteTransactionsDone` once the batch is drained.

## Interface
- NUM_SLOTS, 8, descriptor table depth (max channels per batch, 1..64)
- AXI_aclk  in  1  clock; all logic rising-edge
- AXI_areset  in  1  reset; one clock, reset is synchronous and active-high
- arbSample  in  1  descriptor strobe, one cycle per channel
- arbCurrentChannelSample  in  6  channel id of sampled descriptor
- arbChannelPriority  in  4  priority; larger value wins
- arbChannelTransferSize  in  32  transfer size in bytes
- arbitrate  in  1  one-cycle pulse; start serving collected batch
- arbWriteTransactionsDone  out  1  one-cycle pulse; batch fully drained
- ch_id  out  6  id of channel just completed; valid with ch_done
- ch_done  out  1  one-cycle completion pulse
- xfer_valid  out  1  grant to transfer engine
- xfer_ready  in  1  engine accepts grant
- xfer_ch_id  out  6  granted channel id; stable while xfer_valid
- xfer_size  out  32  granted size; stable while xfer_valid
- xfer_done  in  1  one-cycle pulse; granted transfer finished
- busy  out  1  high in any state other than IDLE
- sample_overflow  out  1  sticky; a sample was dropped because the table was full

## Operation
- Table: NUM_SLOTS entries of {valid, id[5:0], prio[3:0], size[31:0]}.
- Sampling, IDLE only:
  - If a valid slot already holds the same id, that slot is overwritten in place.
  - Otherwise the lowest-index free slot is written.
  - If no slot is free, the sample is dropped and sample_overflow is set.
- arbSample outside IDLE is ignored; the table is not modified.
- FSM states: IDLE, SELECT, ISSUE, WAIT, DONE, FINISH.
- IDLE: on arbitrate, go to SELECT. sample_overflow is cleared on that same edge. If arbSample and arbitrate arrive together, the sample is stored first and is part of the batch.
- SELECT, one cycle: pick the valid slot with the largest prio; ties go to the lowest slot index.
  - No valid slot: go to FINISH.
  - Winner size == 0: go straight to DONE without issuing.
  - Otherwise latch the winner into xfer_ch_id/xfer_size and go to ISSUE.
- ISSUE: xfer_valid=1. On xfer_valid && xfer_ready, go to WAIT. xfer_done seen in ISSUE is ignored.
- WAIT: on xfer_done, go to DONE.
- DONE, one cycle:
  - ch_done=1 and ch_id=winner id.
  - The winner slot's valid bit is cleared on this edge.
  - Next state is SELECT.
- FINISH, one cycle: arbWriteTransactionsDone=1, then IDLE.
- arbitrate outside IDLE is ignored.
- An empty batch (arbitrate with no valid slots) runs IDLE→SELECT→FINISH, giving a done pulse 2 cycles after arbitrate.

## Timing
- All outputs are registered. Reset values:
  - xfer_valid=0, xfer_ch_id=0, xfer_size=0
  - ch_done=0, ch_id=0
  - arbWriteTransactionsDone=0
  - busy=0, sample_overflow=0
  - all slot valid bits=0; state=IDLE
- Sample written at cycle N is visible to a SELECT in cycle N+1 or later.
- arbitrate at cycle N → SELECT in N+1 → xfer_valid high from N+2.
- Handshake at cycle M (valid&&ready) → WAIT from M+1; xfer_valid low in M+1.
- xfer_done at cycle K → ch_done high in K+1 → SELECT in K+2 → next xfer_valid in K+3.
- Zero-size winner: SELECT in S → ch_done in S+1.
- Last ch_done at cycle D → SELECT in D+1 → arbWriteTransactionsDone in D+2.
- xfer_ch_id/xfer_size hold steady from ISSUE through DONE.
- Reset asserted in any state: next edge returns to IDLE with all outputs and the table at reset values. An in-flight grant is abandoned; a xfer_done that arrives after reset is ignored.

## Test plan
- Sample ids 3 (p2, 64B), 5 (p7, 128B), 9 (p7, 32B); arbitrate; engine ready immediately, done 4 cycles after handshake → grant/ch_done order 5, 9, 3; arbWriteTransactionsDone 2 cycles after the third ch_done; busy low afterwards.
- Arbitrate with an empty table → arbWriteTransactionsDone exactly 2 cycles after arbitrate; no xfer_valid, no ch_done.
- Fill NUM_SLOTS=8 slots, then send a 9th sample (id 40) → sample_overflow=1 and id 40 is never granted. Re-sample id 3 with p15 → id 3 is served first. sample_overflow clears on arbitrate.
- Hold xfer_ready low 10 cycles → xfer_valid, xfer_ch_id, xfer_size stable throughout. Pulse xfer_done during ISSUE → no ch_done.
- Channel with size 0 plus channel 7 (p1, 16B) → ch_done for the size-0 channel 1 cycle after its SELECT with no xfer_valid; then channel 7 granted normally.
- Assert AXI_areset while in WAIT → all outputs 0 next cycle. A subsequent xfer_done produces no ch_done. A new batch of one sample works normally.
